buf_rr_sched: RTL

BUF_RR_SCHED -- requirements
Module: buf_rr_sched

---
 rtl/buf_rr_sched_if.sv | 27 ++
 rtl/buf_rr_sched.sv | 134 +++++++++++++
 2 files changed

// File: rtl/buf_rr_sched_if.sv
// Handshake bundle for buf_rr_sched: requester write side, consumer read side and status.
// The slave modport is the scheduler's view; the master modport is the environment's view.
interface buf_rr_sched_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int NREQ  = 2
);
  logic [NREQ-1:0]            req_valid;
  logic [NREQ*WIDTH-1:0]      req_data;
  logic [NREQ-1:0]            req_ready;
  logic                       out_valid;
  logic [WIDTH-1:0]           out_data;
  logic [$clog2(NREQ)-1:0]    out_src;
  logic                       out_ready;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic [1:0]                 state;

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_src, count, state
  );

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_src, count, state
  );
endinterface

// File: rtl/buf_rr_sched.sv
// Round-robin scheduler feeding NREQ requesters into one shared DEPTH-entry circular buffer.
// Each head entry carries the writer's index; status is the occupancy count plus a registered state.
module buf_rr_sched #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int NREQ  = 2
) (
  input logic             clk,
  input logic             rst,
  buf_rr_sched_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(NREQ);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    FULL   = 2'b10
  } state_t;

  logic [WIDTH-1:0] r_mem_data [DEPTH];
  logic [SW-1:0]    r_mem_src  [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [SW-1:0]    r_prio;
  state_t           r_state;

  logic [WIDTH-1:0] w_req_word [NREQ];
  logic             w_full;
  logic             w_empty;
  logic [NREQ-1:0]  w_grant;
  logic [SW-1:0]    w_gidx;
  logic             w_found;
  logic [SW:0]      w_sum;
  logic             w_wr;
  logic             w_pop;
  logic [CW-1:0]    w_count_next;
  logic [SW-1:0]    w_prio_next;
  state_t           w_state_next;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign w_req_word[gi] = bus.req_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // Search upward from r_prio modulo NREQ; first valid requester wins.
  always_comb begin
    w_gidx  = '0;
    w_found = 1'b0;
    w_sum   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, r_prio} + (SW+1)'(k);
      if (w_sum >= (SW+1)'(NREQ)) begin
        w_sum = w_sum - (SW+1)'(NREQ);
      end
      if (!w_found && bus.req_valid[w_sum[SW-1:0]]) begin
        w_found = 1'b1;
        w_gidx  = w_sum[SW-1:0];
      end
    end
  end

  // A full buffer never grants, even if the head is popped this cycle.
  assign w_wr  = w_found && !w_full && !rst;
  assign w_pop = !w_empty && bus.out_ready;

  always_comb begin
    w_grant = '0;
    if (w_wr) begin
      w_grant[w_gidx] = 1'b1;
    end
  end

  always_comb begin
    w_count_next = r_count;
    if (w_wr && !w_pop) begin
      w_count_next = r_count + CW'(1);
    end else if (!w_wr && w_pop) begin
      w_count_next = r_count - CW'(1);
    end
  end

  assign w_prio_next = (w_gidx == SW'(NREQ-1)) ? '0 : w_gidx + SW'(1);

  always_comb begin
    w_state_next = ACTIVE;
    if (w_count_next == '0) begin
      w_state_next = IDLE;
    end else if (w_count_next == CW'(DEPTH)) begin
      w_state_next = FULL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_prio   <= '0;
      r_state  <= IDLE;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        r_prio   <= w_prio_next;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_next;
      r_state <= w_state_next;
    end
  end

  // Storage is left unreset; entries are only observable once counted as occupied.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem_data[r_wr_ptr] <= w_req_word[w_gidx];
      r_mem_src[r_wr_ptr]  <= w_gidx;
    end
  end

  assign bus.req_ready = w_grant;
  assign bus.out_valid = !w_empty;
  assign bus.out_data  = r_mem_data[r_rd_ptr];
  assign bus.out_src   = r_mem_src[r_rd_ptr];
  assign bus.count     = r_count;
  assign bus.state     = r_state;
endmodule
